// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: load-response wait, subword extraction, flush discard, ID forwarding.
// Optional MEM_SUBWORD_LD_EN enables byte/halfword extraction; otherwise loads return the raw word.
module mem_stage_lsu #(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int RA_W = 5,
  localparam int ES_BUS_W = 5 + RA_W + XLEN + PC_W,
  localparam int MS_BUS_W = 1 + RA_W + XLEN + PC_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                es_to_ms_valid,
  input  logic [ES_BUS_W-1:0] es_to_ms_bus,
  output logic                ms_allowin,
  input  logic                ws_allowin,
  output logic                ms_to_ws_valid,
  output logic [MS_BUS_W-1:0] ms_to_ws_bus,
  input  logic                flush,
  input  logic                data_rvalid,
  input  logic [XLEN-1:0]     data_rdata,
  output logic                ms_fwd_valid,
  output logic [RA_W-1:0]     ms_fwd_dest,
  output logic [XLEN-1:0]     ms_fwd_data,
  output logic                ms_fwd_busy
);

  logic                ms_valid_q, ms_valid_d;
  logic                data_have_q, data_have_d;
  logic                discard_q, discard_d;
  logic [ES_BUS_W-1:0] bus_q;
  logic [XLEN-1:0]     rdata_q;

  logic [2:0]      ld_op;
  logic            res_from_mem;
  logic            gr_we;
  logic [RA_W-1:0] dest;
  logic [XLEN-1:0] alu_result;
  logic [PC_W-1:0] pc;

  logic            ms_ready_go;
  logic            wait_st;
  logic            ms_entry;
  logic [XLEN-1:0] ld_word;
  logic [XLEN-1:0] ld_ext;
  logic [XLEN-1:0] final_result;

  assign {ld_op, res_from_mem, gr_we, dest, alu_result, pc} = bus_q;

  assign wait_st     = ms_valid_q && res_from_mem && !data_have_q;
  assign ms_ready_go = !res_from_mem || data_have_q || data_rvalid;
  assign ms_allowin  = !discard_q &&
                       (!ms_valid_q || (ms_ready_go && ws_allowin));
  assign ms_entry    = es_to_ms_valid && ms_allowin;

  // Next-state for valid, load-data-held and orphan-discard flags
  always_comb begin
    ms_valid_d  = ms_valid_q;
    data_have_d = data_have_q;
    discard_d   = discard_q;
    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end else if (flush) begin
      ms_valid_d = 1'b0;
    end
    if (ms_allowin || flush) begin
      data_have_d = 1'b0;
    end else if (wait_st && data_rvalid) begin
      data_have_d = 1'b1;
    end
    if (discard_q && data_rvalid) begin
      discard_d = 1'b0;
    end else if (flush && wait_st && !data_rvalid) begin
      discard_d = 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      data_have_q <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      data_have_q <= data_have_d;
      discard_q   <= discard_d;
    end
  end

  // Payload registers: instruction bus on entry, load word on first response
  always_ff @(posedge clk) begin
    if (ms_entry) begin
      bus_q <= es_to_ms_bus;
    end
    if (wait_st && data_rvalid) begin
      rdata_q <= data_rdata;
    end
  end

  assign ld_word = data_rvalid ? data_rdata : rdata_q;

`ifdef MEM_SUBWORD_LD_EN
  logic [XLEN-1:0] b_shift;
  logic [XLEN-1:0] h_shift;
  logic [7:0]      b_val;
  logic [15:0]     h_val;

  assign b_shift = ld_word >> {alu_result[1:0], 3'b000};
  assign h_shift = ld_word >> {alu_result[1], 4'b0000};
  assign b_val   = b_shift[7:0];
  assign h_val   = h_shift[15:0];

  // Byte/halfword selection with sign or zero extension
  always_comb begin
    ld_ext = ld_word;
    case (ld_op)
      3'b001:  ld_ext = {{(XLEN-8){b_val[7]}}, b_val};
      3'b101:  ld_ext = {{(XLEN-8){1'b0}}, b_val};
      3'b010:  ld_ext = {{(XLEN-16){h_val[15]}}, h_val};
      3'b110:  ld_ext = {{(XLEN-16){1'b0}}, h_val};
      default: ld_ext = ld_word;
    endcase
  end
`else
  logic unused_ld_op;
  assign unused_ld_op = ^ld_op;
  assign ld_ext = ld_word;
`endif

  assign final_result = res_from_mem ? ld_ext : alu_result;

  assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
  assign ms_to_ws_bus   = {gr_we, dest, final_result, pc};

  assign ms_fwd_valid = ms_valid_q && gr_we;
  assign ms_fwd_dest  = dest;
  assign ms_fwd_data  = final_result;
  assign ms_fwd_busy  = ms_valid_q && res_from_mem &&
                        !data_have_q && !data_rvalid;

endmodule
